hazard_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the PC, IF_ID, ID_EX and EX_MEM

---
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and data-memory wait hazards,
// plus a memory-wait watchdog and saturating performance counters. Control outputs are combinational.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             fault,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mw_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

    logic freeze;
    logic load_use;
    logic lu_issue;
    logic br_issue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        freeze   = ((state_q == RUN) && mem_req && !mem_ready)
                 || ((state_q == MEM_WAIT) && !mem_ready)
                 || (state_q == FAULT);
        load_use = ex_mem_read && (ex_rd != 5'd0)
                 && ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        lu_issue     = 1'b0;
        br_issue     = 1'b0;

        // A hazard masked by a freeze stays in the held stage registers and resurfaces on release.
        if (!reset) begin
            if (freeze) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                br_issue    = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                lu_issue    = 1'b1;
            end
        end

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase

        fault_d  = (state_d == FAULT);
        lu_cnt_d = sat_inc(lu_cnt_q, lu_issue);
        br_cnt_d = sat_inc(br_cnt_q, br_issue);
        mw_cnt_d = sat_inc(mw_cnt_q, freeze && (state_q != FAULT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
            lu_cnt_q   <= '0;
            br_cnt_q   <= '0;
            mw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            lu_cnt_q   <= lu_cnt_d;
            br_cnt_q   <= br_cnt_d;
            mw_cnt_q   <= mw_cnt_d;
        end
    end

    assign fault  = fault_q;
    assign lu_cnt = lu_cnt_q;
    assign br_cnt = br_cnt_q;
    assign mw_cnt = mw_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl with a short watchdog and 2-bit counters; expected per-cycle results
// are queued as each cycle is driven and compared against the sampled outputs.
module tb_hazard_stall_ctrl;

    localparam int MT = 4;
    localparam int CW = 2;

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110010;
    localparam logic [5:0] O_BR   = 6'b001010;
    localparam logic [5:0] O_FRZ  = 6'b110101;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       exr;
        logic [4:0] exrd;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
    } stim_t;

    typedef struct packed {
        logic [5:0]    outs;
        logic          flt;
        logic [CW-1:0] lu;
        logic [CW-1:0] br;
        logic [CW-1:0] mw;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, fault;
    logic [CW-1:0] lu_cnt, br_cnt, mw_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .fault           (fault),
        .lu_cnt          (lu_cnt),
        .br_cnt          (br_cnt),
        .mw_cnt          (mw_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic stim_t st(input logic rst, input logic br, input logic mreq, input logic mrdy,
                                 input logic exr, input logic [4:0] exrd, input logic [4:0] rs1,
                                 input logic use1, input logic [4:0] rs2, input logic use2);
        stim_t s;
        s.rst = rst; s.br = br; s.mreq = mreq; s.mrdy = mrdy; s.exr = exr;
        s.exrd = exrd; s.rs1 = rs1; s.use1 = use1; s.rs2 = rs2; s.use2 = use2;
        return s;
    endfunction

    function automatic exp_t ex(input logic [5:0] outs, input logic flt, input int lu,
                                input int br, input int mw);
        exp_t e;
        e.outs = outs; e.flt = flt;
        e.lu = CW'(lu); e.br = CW'(br); e.mw = CW'(mw);
        return e;
    endfunction

    // Drive one cycle at the falling edge, queue its expectation, compare just before the rising edge.
    task automatic run_cycle(input string tag, input stim_t s, input exp_t e);
        exp_t want;
        @(negedge clk);
        reset           = s.rst;
        ex_branch_taken = s.br;
        mem_req         = s.mreq;
        mem_ready       = s.mrdy;
        ex_mem_read     = s.exr;
        ex_rd           = s.exrd;
        id_rs1          = s.rs1;
        id_use_rs1      = s.use1;
        id_rs2          = s.rs2;
        id_use_rs2      = s.use2;
        exp_q.push_back(e);
        #4;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check_eq({tag, "_ctl"}, {26'd0, pc_stall, if_id_stall, if_id_flush,
                                     id_ex_stall, id_ex_flush, ex_mem_stall}, {26'd0, want.outs});
            check_eq({tag, "_fault"}, {31'd0, fault}, {31'd0, want.flt});
            check_eq({tag, "_lu"}, 32'(lu_cnt), 32'(want.lu));
            check_eq({tag, "_br"}, 32'(br_cnt), 32'(want.br));
            check_eq({tag, "_mw"}, 32'(mw_cnt), 32'(want.mw));
        end
    endtask

    stim_t idle;

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        idle = st(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        @(posedge clk);

        // reset masks hazards and freezes
        run_cycle("rst0",   st(1, 1, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_NONE, 0, 0, 0, 0));
        // load-use handling
        run_cycle("lu_rs1", st(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_LU,   0, 0, 0, 0));
        run_cycle("lu_one", idle,                                      ex(O_NONE, 0, 1, 0, 0));
        run_cycle("lu_x0",  st(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0), ex(O_NONE, 0, 1, 0, 0));
        run_cycle("lu_nou", st(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0), ex(O_NONE, 0, 1, 0, 0));
        run_cycle("lu_nold",st(0, 0, 0, 0, 0, 5'd7, 5'd3, 1, 5'd7, 1), ex(O_NONE, 0, 1, 0, 0));
        run_cycle("lu_rs2", st(0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1), ex(O_LU,   0, 1, 0, 0));
        run_cycle("lu_cnt", idle,                                      ex(O_NONE, 0, 2, 0, 0));
        // branch overrides a simultaneous load-use
        run_cycle("br_lu",  st(0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_BR,   0, 2, 0, 0));
        run_cycle("br_cnt", idle,                                      ex(O_NONE, 0, 2, 1, 0));
        run_cycle("rst1",   st(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_NONE, 0, 2, 1, 0));

        // memory wait of 3 cycles, released on the last legal count; hazard resurfaces on release
        run_cycle("mw0",    st(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 0));
        run_cycle("mw1",    st(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 1));
        run_cycle("mw2",    st(0, 1, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 2));
        run_cycle("mw_rdy", st(0, 0, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_LU,   0, 0, 0, 3));
        run_cycle("mw_end", idle,                                      ex(O_NONE, 0, 1, 0, 3));
        run_cycle("mw_run", st(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_NONE, 0, 1, 0, 3));
        run_cycle("rst2",   st(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_NONE, 0, 1, 0, 3));

        // watchdog: MT frozen cycles then sticky fault, ready ignored, branch never issued
        run_cycle("wd0",    st(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 0));
        run_cycle("wd1",    st(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 1));
        run_cycle("wd2",    st(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 2));
        run_cycle("wd3",    st(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  0, 0, 0, 3));
        run_cycle("wd_flt", st(0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_FRZ,  1, 0, 0, 3));
        run_cycle("wd_rdy", st(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0), ex(O_FRZ,  1, 0, 0, 3));
        run_cycle("wd_hold",idle,                                      ex(O_FRZ,  1, 0, 0, 3));
        run_cycle("rst3",   st(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0), ex(O_NONE, 1, 0, 0, 3));
        run_cycle("clr",    idle,                                      ex(O_NONE, 0, 0, 0, 0));

        // branch counter saturation at 2 bits
        for (int i = 0; i < 5; i++) begin
            run_cycle($sformatf("sat%0d", i), st(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0),
                      ex(O_BR, 0, 0, (i > 3) ? 3 : i, 0));
        end
        run_cycle("sat_end", idle,                                     ex(O_NONE, 0, 0, 3, 0));

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
